ray_issue_scheduler: RTL and testbench

Frame-level sequencer for the eye-to-pixel ray-direction pipeline. On frame_start it snapshots the head position and holds it stable for the whole frame. It waits for the head-dependent constant conversions to settle, then issues pixel coordinates in raster order under credit-based flow control. It counts returned direction results and pulses frame_done once every pixel's ray has come back.

---
 rtl/ray_pkg.sv | 27 ++
 rtl/credit_counter.sv | 55 +++++
 rtl/ray_issue_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_ray_issue_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_pkg.sv
// ray_pkg
// Shared types and constants for the eye-to-pixel ray-direction pipeline.
//   - ray_sched_state_t : frame sequencer states
//   - DEF_H_PIXELS / DEF_V_PIXELS : default screen size, shared with the
//     half-width / half-height constants of the eye-to-pixel stage
//   - X_W / Y_W / RES_W : pixel coordinate and result counter widths
package ray_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_DRAIN  = 2'd3
    } ray_sched_state_t;

    localparam int DEF_H_PIXELS = 512;
    localparam int DEF_V_PIXELS = 384;

    // Screen-centre offsets used when turning a pixel index into a view ray.
    localparam int HALF_WIDTH  = DEF_H_PIXELS / 2;
    localparam int HALF_HEIGHT = DEF_V_PIXELS / 2;

    localparam int X_W   = 11;
    localparam int Y_W   = 10;
    localparam int RES_W = 19;

endpackage

// File: rtl/credit_counter.sv
// credit_counter
// Up/down counter for credit-based flow control toward a downstream buffer.
// Resets full (MAX_COUNT), never goes below zero, and refuses to count past
// MAX_COUNT: an increment while already full is dropped and flagged.
// Ports:
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset
//   inc_i      : one credit returned by the consumer
//   dec_i      : one credit spent by the producer
//   count_o    : registered credit count
//   overflow_o : high in a cycle where inc_i is dropped because count is full
module credit_counter #(
    parameter int MAX_COUNT = 128,
    parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_COUNT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // A simultaneous spend and return cancel out, so only a lone increment
    // can overflow and only a lone decrement can underflow.
    always_comb begin
        count_d    = count_q;
        overflow_o = 1'b0;
        if (inc_i && !dec_i) begin
            if (count_q == FULL) begin
                overflow_o = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= FULL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ray_issue_scheduler.sv
// ray_issue_scheduler
// Frame-level sequencer for the ray-direction pipeline. A frame_start in IDLE
// freezes the head position, waits SETTLE_CYCLES for the head-dependent
// constants to settle, issues every pixel in raster order while downstream
// credits are available, then waits for all results and pulses frame_done.
// Ports:
//   clk_in, rst_in_n             : clock, asynchronous active-low reset
//   frame_start                  : frame request (accepted only in IDLE)
//   head_{x,y,z}_in              : head position, float32
//   head_{x,y,z}_out             : head position frozen for the frame
//   x_out, y_out, valid_out      : issued pixel coordinate
//   dir_valid_in                 : one result strobe per issued pixel
//   credit_return                : downstream freed one ray slot
//   busy, frame_done, err_sticky : frame status and sticky protocol error
module ray_issue_scheduler
    import ray_pkg::*;
#(
    parameter int H_PIXELS      = DEF_H_PIXELS,
    parameter int V_PIXELS      = DEF_V_PIXELS,
    parameter int SETTLE_CYCLES = 8,
    parameter int MAX_CREDITS   = 128
) (
    input  logic           clk_in,
    input  logic           rst_in_n,
    input  logic           frame_start,
    input  logic [31:0]    head_x_in,
    input  logic [31:0]    head_y_in,
    input  logic [31:0]    head_z_in,
    output logic [31:0]    head_x_out,
    output logic [31:0]    head_y_out,
    output logic [31:0]    head_z_out,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic           valid_out,
    input  logic           dir_valid_in,
    input  logic           credit_return,
    output logic           busy,
    output logic           frame_done,
    output logic           err_sticky
);

    localparam int CRED_W = $clog2(MAX_CREDITS + 1);
    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);

    localparam logic [X_W-1:0]   X_LAST    = X_W'(H_PIXELS - 1);
    localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(V_PIXELS - 1);
    localparam logic [RES_W-1:0] RES_TOTAL = RES_W'(H_PIXELS * V_PIXELS);
    localparam logic [SET_W-1:0] SET_LOAD  = SET_W'(SETTLE_CYCLES - 1);

    ray_sched_state_t state_q, state_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [RES_W-1:0] res_q, res_d;
    logic [31:0]      headX_q, headX_d;
    logic [31:0]      headY_q, headY_d;
    logic [31:0]      headZ_q, headZ_d;
    logic [X_W-1:0]   xOut_q, xOut_d;
    logic [Y_W-1:0]   yOut_q, yOut_d;
    logic             validOut_q, validOut_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [CRED_W-1:0] creditCount;
    logic              creditOverflow;
    logic              issue;

    // Issuing depends only on the registered credit count, so a same-cycle
    // credit_return never creates a combinational input-to-output path.
    assign issue = (state_q == ST_ISSUE) && (creditCount != '0);

    credit_counter #(
        .MAX_COUNT (MAX_CREDITS),
        .CNT_W     (CRED_W)
    ) u_credits (
        .clk_i      (clk_in),
        .rst_ni     (rst_in_n),
        .inc_i      (credit_return),
        .dec_i      (issue),
        .count_o    (creditCount),
        .overflow_o (creditOverflow)
    );

    // Next-state logic for the frame sequencer, raster counters, result
    // counter and all registered outputs.
    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        x_d        = x_q;
        y_d        = y_q;
        res_d      = res_q;
        headX_d    = headX_q;
        headY_d    = headY_q;
        headZ_d    = headZ_q;
        xOut_d     = xOut_q;
        yOut_d     = yOut_q;
        validOut_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q | creditOverflow;

        // A result with no frame in flight is a protocol error, not a count.
        if (dir_valid_in) begin
            if (state_q == ST_IDLE) begin
                err_d = 1'b1;
            end else begin
                res_d = res_q + 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    headX_d  = head_x_in;
                    headY_d  = head_y_in;
                    headZ_d  = head_z_in;
                    x_d      = '0;
                    y_d      = '0;
                    res_d    = '0;
                    settle_d = SET_LOAD;
                    busy_d   = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_ISSUE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    validOut_d = 1'b1;
                    xOut_d     = x_q;
                    yOut_d     = y_q;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d     = '0;
                            state_d = ST_DRAIN;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Uses the post-increment count so the last result's own
                // arrival cycle completes the frame.
                if (res_d == RES_TOTAL) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q    <= ST_IDLE;
            settle_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            res_q      <= '0;
            headX_q    <= '0;
            headY_q    <= '0;
            headZ_q    <= '0;
            xOut_q     <= '0;
            yOut_q     <= '0;
            validOut_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            x_q        <= x_d;
            y_q        <= y_d;
            res_q      <= res_d;
            headX_q    <= headX_d;
            headY_q    <= headY_d;
            headZ_q    <= headZ_d;
            xOut_q     <= xOut_d;
            yOut_q     <= yOut_d;
            validOut_q <= validOut_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign head_x_out = headX_q;
    assign head_y_out = headY_q;
    assign head_z_out = headZ_q;
    assign x_out      = xOut_q;
    assign y_out      = yOut_q;
    assign valid_out  = validOut_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_ray_issue_scheduler.sv
// tb_ray_issue_scheduler
// Scoreboard bench for ray_issue_scheduler on a 4x2 screen with 3 credits.
// Expected coordinates are queued when a frame is requested and popped as
// valid_out beats appear; a monitor feeds results back through a 117-cycle
// delay line and optionally echoes one credit per beat.
module tb_ray_issue_scheduler;
    import ray_pkg::*;

    localparam int H         = 4;
    localparam int V         = 2;
    localparam int SETTLE    = 2;
    localparam int MAXC      = 3;
    localparam int DIR_DELAY = 117;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           frame_start;
    logic [31:0]    head_x_in, head_y_in, head_z_in;
    logic [31:0]    head_x_out, head_y_out, head_z_out;
    logic [X_W-1:0] x_out;
    logic [Y_W-1:0] y_out;
    logic           valid_out;
    logic           dir_valid_in;
    logic           credit_return;
    logic           busy, frame_done, err_sticky;

    int checkCnt = 0;
    int passCnt  = 0;

    // Scoreboard and monitor state
    logic [20:0] coordQ[$];
    int          dirQ[$];
    int          beatCycle[$];
    logic [20:0] lastXY = '0;
    int cycle        = 0;
    int beats        = 0;
    int doneCnt      = 0;
    int doneCycle    = -1;
    int lastDirCycle = -1;
    int creditServed = 0;
    int dirServed    = 0;

    // Controls written by the main sequence only
    logic echoEn     = 1'b0;
    int   creditReq  = 0;
    int   dirReq     = 0;
    int   fsCycle    = 0;
    int   beatBase   = 0;
    int   doneBase   = 0;

    always #5 clk = ~clk;

    ray_issue_scheduler #(
        .H_PIXELS      (H),
        .V_PIXELS      (V),
        .SETTLE_CYCLES (SETTLE),
        .MAX_CREDITS   (MAXC)
    ) dut (
        .clk_in        (clk),
        .rst_in_n      (rst_n),
        .frame_start   (frame_start),
        .head_x_in     (head_x_in),
        .head_y_in     (head_y_in),
        .head_z_in     (head_z_in),
        .head_x_out    (head_x_out),
        .head_y_out    (head_y_out),
        .head_z_out    (head_z_out),
        .x_out         (x_out),
        .y_out         (y_out),
        .valid_out     (valid_out),
        .dir_valid_in  (dir_valid_in),
        .credit_return (credit_return),
        .busy          (busy),
        .frame_done    (frame_done),
        .err_sticky    (err_sticky)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCnt++;
        if (actual === expected) begin
            passCnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) nextCycle();
    endtask

    task automatic pushFrame();
        for (int yy = 0; yy < V; yy++)
            for (int xx = 0; xx < H; xx++)
                coordQ.push_back({X_W'(xx), Y_W'(yy)});
    endtask

    // Present a head position and pulse frame_start for one cycle.
    task automatic applyStimulus(input logic [31:0] hx, input logic [31:0] hy, input logic [31:0] hz);
        head_x_in   = hx;
        head_y_in   = hy;
        head_z_in   = hz;
        frame_start = 1'b1;
        fsCycle     = cycle;
        nextCycle();
        frame_start = 1'b0;
    endtask

    task automatic waitBeats(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (beats < target && n < budget) begin
            nextCycle();
            n++;
        end
        if (beats < target) checkOutput(tag, 64'(beats), 64'(target));
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (doneCnt == doneBase && n < budget) begin
            nextCycle();
            n++;
        end
        if (doneCnt == doneBase) checkOutput("frame_done timeout", 64'd0, 64'd1);
    endtask

    // Monitor: scoreboard beats, record frame_done, drive result and credit
    // returns for the following rising edge.
    initial begin
        logic dir;
        dir_valid_in  = 1'b0;
        credit_return = 1'b0;
        forever begin
            @(negedge clk);
            cycle++;
            if (!rst_n) begin
                dirQ.delete();
                dir_valid_in  = 1'b0;
                credit_return = 1'b0;
            end else begin
                if (valid_out) begin
                    beats++;
                    beatCycle.push_back(cycle);
                    lastXY = {x_out, y_out};
                    if (coordQ.size() == 0) begin
                        checkOutput("unexpected beat", 64'd1, 64'd0);
                    end else begin
                        checkOutput("beat coord", 64'({x_out, y_out}), 64'(coordQ.pop_front()));
                    end
                    dirQ.push_back(cycle + DIR_DELAY);
                end
                if (frame_done) begin
                    doneCnt++;
                    doneCycle = cycle;
                end
                dir = 1'b0;
                if (dirQ.size() > 0 && dirQ[0] == cycle) begin
                    void'(dirQ.pop_front());
                    dir = 1'b1;
                end
                if (dirReq > dirServed) begin
                    dir = 1'b1;
                    dirServed++;
                end
                if (dir) lastDirCycle = cycle;
                dir_valid_in  = dir;
                credit_return = echoEn && valid_out;
                if (creditReq > creditServed) begin
                    credit_return = 1'b1;
                    creditServed++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        head_x_in   = '0;
        head_y_in   = '0;
        head_z_in   = '0;
        waitCycles(3);
        checkOutput("reset ctrl", 64'({valid_out, busy, frame_done, err_sticky}), 64'd0);
        checkOutput("reset coord", 64'({x_out, y_out}), 64'd0);
        checkOutput("reset head xy", {head_x_out, head_y_out}, 64'd0);
        checkOutput("reset head z", 64'(head_z_out), 64'd0);
        rst_n = 1'b1;
        waitCycles(2);

        // Basic frame with head snapshot and ignored frame_starts
        $display("[TB] basic frame");
        echoEn   = 1'b1;
        pushFrame();
        beatBase = beats;
        doneBase = doneCnt;
        applyStimulus(32'h44E10000, 32'h40000000, 32'hC0400000);
        checkOutput("busy after start", 64'(busy), 64'd1);
        head_x_in   = 32'h3F800000;
        frame_start = 1'b1;
        nextCycle();
        frame_start = 1'b0;
        waitBeats(beatBase + 1, 20, "first beat timeout");
        if (beatCycle.size() > beatBase)
            checkOutput("first beat latency", 64'((beatCycle[beatBase] - (fsCycle + 1)) >= SETTLE + 1), 64'd1);
        frame_start = 1'b1;
        nextCycle();
        frame_start = 1'b0;
        waitBeats(beatBase + H * V, 40, "all beats timeout");
        checkOutput("busy in drain", 64'(busy), 64'd1);
        checkOutput("head x frozen", 64'(head_x_out), 64'h44E10000);
        checkOutput("head yz frozen", {head_y_out, head_z_out}, 64'h40000000_C0400000);
        frame_start = 1'b1;
        nextCycle();
        frame_start = 1'b0;
        waitDone(300);
        checkOutput("done 1 after last result", 64'(doneCycle - lastDirCycle), 64'd1);
        checkOutput("busy low at done", 64'(busy), 64'd0);
        waitCycles(10);
        checkOutput("frame1 beats", 64'(beats - beatBase), 64'(H * V));
        checkOutput("frame1 done pulses", 64'(doneCnt - doneBase), 64'd1);
        checkOutput("head held in idle", 64'(head_x_out), 64'h44E10000);
        checkOutput("no err on ignored starts", 64'(err_sticky), 64'd0);

        // Credit stall
        $display("[TB] credit stall");
        echoEn   = 1'b0;
        pushFrame();
        beatBase = beats;
        doneBase = doneCnt;
        applyStimulus(32'h3F800000, 32'h00000000, 32'h41200000);
        waitCycles(30);
        checkOutput("stall beats", 64'(beats - beatBase), 64'(MAXC));
        checkOutput("stall valid low", 64'(valid_out), 64'd0);
        checkOutput("head new frame", 64'(head_x_out), 64'h3F800000);
        creditReq++;
        waitCycles(20);
        checkOutput("one credit one beat", 64'(beats - beatBase), 64'(MAXC + 1));
        checkOutput("fourth beat coord", 64'(lastXY), 64'({X_W'(3), Y_W'(0)}));
        creditReq++;
        waitCycles(5);
        checkOutput("fifth beat", 64'(beats - beatBase), 64'd5);

        // Asynchronous reset mid-ISSUE
        $display("[TB] async reset");
        rst_n = 1'b0;
        #1;
        checkOutput("async rst ctrl", 64'({valid_out, busy, frame_done, err_sticky}), 64'd0);
        checkOutput("async rst coord", 64'({x_out, y_out}), 64'd0);
        checkOutput("async rst head", {head_x_out, head_y_out}, 64'd0);
        nextCycle();
        coordQ.delete();
        nextCycle();
        rst_n = 1'b1;
        waitCycles(20);
        checkOutput("no done after abort", 64'(doneCnt - doneBase), 64'd0);

        // Fresh frame after reset starts at (0,0)
        $display("[TB] frame after reset");
        echoEn   = 1'b1;
        pushFrame();
        beatBase = beats;
        doneBase = doneCnt;
        applyStimulus(32'h42000000, 32'h42040000, 32'h42080000);
        waitDone(300);
        checkOutput("frame2 beats", 64'(beats - beatBase), 64'(H * V));
        checkOutput("frame2 done timing", 64'(doneCycle - lastDirCycle), 64'd1);
        checkOutput("frame2 err", 64'(err_sticky), 64'd0);

        // Credit return while already full
        $display("[TB] protocol errors");
        waitCycles(2);
        echoEn = 1'b0;
        creditReq++;
        waitCycles(3);
        checkOutput("err on credit overflow", 64'(err_sticky), 64'd1);
        pushFrame();
        beatBase = beats;
        applyStimulus(32'h3F800000, 32'h3F800000, 32'h3F800000);
        waitCycles(25);
        checkOutput("credits stay max", 64'(beats - beatBase), 64'(MAXC));
        checkOutput("err held", 64'(err_sticky), 64'd1);
        rst_n = 1'b0;
        nextCycle();
        coordQ.delete();
        rst_n = 1'b1;
        nextCycle();
        checkOutput("err cleared by reset", 64'(err_sticky), 64'd0);

        // Result strobe while idle
        dirReq++;
        waitCycles(3);
        checkOutput("err on idle result", 64'(err_sticky), 64'd1);
        echoEn   = 1'b1;
        pushFrame();
        beatBase = beats;
        doneBase = doneCnt;
        applyStimulus(32'h40400000, 32'h40800000, 32'h40A00000);
        waitDone(300);
        checkOutput("frame3 beats", 64'(beats - beatBase), 64'(H * V));
        checkOutput("frame3 done timing", 64'(doneCycle - lastDirCycle), 64'd1);
        checkOutput("err still held", 64'(err_sticky), 64'd1);
        checkOutput("scoreboard empty", 64'(coordQ.size()), 64'd0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
